irq_gen: RTL and testbench
==========================

# irq_gen

Core-local interrupt source that produces the one-hot asynchronous interrupt bus consumed by the commit/interrupt-arbitration stage. It owns the machine timer (mtime/mtimecmp), the software-interrupt bit (msip), the external-interrupt input and a latched debug request. It arbitrates these into a single registered one-hot `irq_o` and holds it until the core acknowledges entry. Software-visible registers sit on a simple single-cycle peripheral register port.

## Interface
- `PRESCALE`, default 1: mtime increments once every PRESCALE clocks; legal range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `sel_i`  in  1  register access strobe.
- `we_i`  in  1  1 = write, 0 = read; qualified by `sel_i`.
- `addr_i`  in  5  byte offset; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data, valid the cycle after a read strobe.
- `ext_irq_i`  in  1  external interrupt, level-sensitive.
- `dbg_req_i`  in  1  debug request, rising-edge latched.
- `int_ack_i`  in  1  one-cycle pulse: core has entered the trap for the current `irq_o`.
- `irq_o`  out  4  one-hot: 0001 software, 0010 timer, 0100 external, 1000 debug; 0000 = none.

## Operation
- Register map:
  - 0x00 msip, bit 0.
  - 0x04 mtimecmp[31:0].
  - 0x08 mtimecmp[63:32].
  - 0x0C mtime[31:0].
  - 0x10 mtime[63:32].
  - 0x14 irq_en[3:0].
  - 0x18 status, read-only: {locked_src[3:0], pending[3:0]} in bits [7:0].
  - Unmapped offsets read 0; writes to them are ignored.
- Reset values: mtime 0, mtimecmp all-ones, msip 0, irq_en 4'b1111, debug latch 0, `irq_o` 0, `rdata_o` 0, prescale counter 0, state S_IDLE.
- mtime: 64-bit unsigned, +1 when the prescale counter reaches PRESCALE-1, wraps from 2^64-1 to 0. A write to either half takes priority over the increment in that cycle. The two halves are written independently with no atomicity.
- Pending bits:
  - software = msip.
  - timer = (mtime >= mtimecmp), unsigned 64-bit compare.
  - external = ext_irq_i, synchronized if configured.
  - debug = debug latch.
- Each pending bit is masked by irq_en.
- Debug latch: set on a 0->1 edge of `dbg_req_i`; cleared by `int_ack_i` while debug is the locked source. Set wins over a simultaneous clear.
- Priority: debug > external > timer > software.
- FSM:
  - S_IDLE: if any masked pending bit is set, lock the highest-priority source into locked_src, drive `irq_o` = locked_src, and go to S_ASSERT.
  - S_ASSERT: `irq_o` is held stable. Higher-priority arrivals do not preempt.
    - On `int_ack_i`: `irq_o` <= 0, go to S_GAP.
    - Else, if the locked source's pending bit drops (level withdrawn or masked): `irq_o` <= 0, go to S_IDLE.
  - S_GAP: `irq_o` = 0 for one cycle, then go to S_IDLE.
- `int_ack_i` in S_IDLE or S_GAP is ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); `irq_o` = 0.

## Timing
- `irq_o` is a register output; there is no combinational path from any input to `irq_o`.
- msip write at edge N: pending at N, `irq_o` valid after edge N+1.
- Timer: mtime reaching mtimecmp at edge N gives `irq_o` after edge N+1.
- External, unsynchronized: `ext_irq_i` sampled high at edge N gives `irq_o` after edge N.
- Ack at edge N: `irq_o` = 0 after N, S_IDLE after N+1. The earliest re-assertion is visible after N+2.
- Reads: `rdata_o` is registered with 1-cycle latency; it holds its last value when there is no read.

## Configuration
- `IRQ_GEN_EXT_SYNC_EN` defined: `ext_irq_i` passes through a 2-flop synchronizer (reset 0) before pending logic, adding 2 cycles of latency.
- Not defined: `ext_irq_i` is used directly and must already be synchronous to `clk`.

## Structure
- The shared defines header carries:
  - The one-hot IRQ codes: IRQ_SOFT, IRQ_TIMER, IRQ_EXT, IRQ_DBG.
  - The register offsets: IRQ_GEN_MSIP ... IRQ_GEN_STATUS.
  - The FSM state encodings.
- One sub-module, `irq_timer`, contains the prescaler, mtime, mtimecmp, write muxing and the compare. It outputs `timer_pend` and the read-back halves.

## Test plan
- Reset, then write 1 to 0x00 -> `irq_o` = 4'b0001 two edges after the write; pulse `int_ack_i` -> `irq_o` = 0 for exactly 2 cycles, then 4'b0001 again (msip still set).
- PRESCALE=1, mtimecmp = 0x0000_0000_0000_0010, mtime = 0 -> `irq_o` = 4'b0010 after the edge at which mtime == 0x10. Write mtimecmp_hi = 0xFFFFFFFF -> `irq_o` withdrawn to 0 within 2 cycles with no ack.
- Debug and msip pending simultaneously from S_IDLE -> `irq_o` = 4'b1000. Ack -> debug latch clears, and `irq_o` = 4'b0001 two cycles later.
- `irq_o` = 4'b0001 locked, then `ext_irq_i` rises -> `irq_o` stays 4'b0001 until ack, then becomes 4'b0100.
- mtime = 0xFFFF_FFFF_FFFF_FFFF -> reads 0 in both halves after the next increment. Write mtime_lo in the same cycle as an increment -> readback equals the written value.
- Assert `rst` while in S_ASSERT -> `irq_o`, `rdata_o` and msip are 0 immediately, and mtimecmp reads 0xFFFFFFFF.

Source files
------------

// File: rtl/irq_gen_pkg.sv
// Shared definitions for irq_gen: one-hot IRQ codes, register offsets,
// FSM state encodings and the priority pick helper.
package irq_gen_pkg;

  // One-hot interrupt codes driven on irq_o
  localparam logic [3:0] IRQ_SOFT  = 4'b0001;
  localparam logic [3:0] IRQ_TIMER = 4'b0010;
  localparam logic [3:0] IRQ_EXT   = 4'b0100;
  localparam logic [3:0] IRQ_DBG   = 4'b1000;

  // Register byte offsets
  localparam logic [4:0] IRQ_GEN_MSIP        = 5'h00;
  localparam logic [4:0] IRQ_GEN_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] IRQ_GEN_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] IRQ_GEN_MTIME_LO    = 5'h0C;
  localparam logic [4:0] IRQ_GEN_MTIME_HI    = 5'h10;
  localparam logic [4:0] IRQ_GEN_IRQ_EN      = 5'h14;
  localparam logic [4:0] IRQ_GEN_STATUS      = 5'h18;

  // Word indices used by the decoders (byte offset with bits [1:0] dropped)
  localparam logic [2:0] W_MSIP        = IRQ_GEN_MSIP[4:2];
  localparam logic [2:0] W_MTIMECMP_LO = IRQ_GEN_MTIMECMP_LO[4:2];
  localparam logic [2:0] W_MTIMECMP_HI = IRQ_GEN_MTIMECMP_HI[4:2];
  localparam logic [2:0] W_MTIME_LO    = IRQ_GEN_MTIME_LO[4:2];
  localparam logic [2:0] W_MTIME_HI    = IRQ_GEN_MTIME_HI[4:2];
  localparam logic [2:0] W_IRQ_EN      = IRQ_GEN_IRQ_EN[4:2];
  localparam logic [2:0] W_STATUS      = IRQ_GEN_STATUS[4:2];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } irq_state_e;

  // Highest-priority set bit: debug > external > timer > software
  function automatic logic [3:0] irq_prio_pick(input logic [3:0] pend);
    logic [3:0] pick;
    pick = 4'b0000;
    if (pend[3])      pick = IRQ_DBG;
    else if (pend[2]) pick = IRQ_EXT;
    else if (pend[1]) pick = IRQ_TIMER;
    else if (pend[0]) pick = IRQ_SOFT;
    return pick;
  endfunction

endpackage

// File: rtl/irq_gen_timer.sv
// irq_timer: prescaler, 64-bit mtime / mtimecmp with register write muxing
// and the unsigned compare that produces the timer pending bit.
module irq_timer
  import irq_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [2:0]  i_word,
  input  logic [31:0] i_wdata,
  output logic        o_timer_pend,
  output logic [31:0] o_mtime_lo,
  output logic [31:0] o_mtime_hi,
  output logic [31:0] o_mtimecmp_lo,
  output logic [31:0] o_mtimecmp_hi
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_presc_cnt;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        w_tick;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;

  assign w_tick        = (r_presc_cnt == PRESC_LAST);
  assign w_wr_mtime_lo = i_wr_en && (i_word == W_MTIME_LO);
  assign w_wr_mtime_hi = i_wr_en && (i_word == W_MTIME_HI);
  assign w_wr_cmp_lo   = i_wr_en && (i_word == W_MTIMECMP_LO);
  assign w_wr_cmp_hi   = i_wr_en && (i_word == W_MTIMECMP_HI);

  // Prescaler: free-running, issues one tick every PRESCALE clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_presc_cnt <= '0;
    else     r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 16'd1;
  end

  // mtime: a write to either half suppresses that cycle's increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo || w_wr_mtime_hi) begin
      if (w_wr_mtime_lo) r_mtime[31:0]  <= i_wdata;
      if (w_wr_mtime_hi) r_mtime[63:32] <= i_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp: halves written independently, resets to never-fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= '1;
    end else begin
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= i_wdata;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= i_wdata;
    end
  end

  assign o_timer_pend  = (r_mtime >= r_mtimecmp);
  assign o_mtime_lo    = r_mtime[31:0];
  assign o_mtime_hi    = r_mtime[63:32];
  assign o_mtimecmp_lo = r_mtimecmp[31:0];
  assign o_mtimecmp_hi = r_mtimecmp[63:32];

endmodule

// File: rtl/irq_gen.sv
// irq_gen: core-local interrupt source. Arbitrates software, timer, external
// and debug requests into a registered one-hot irq_o held until acknowledged.
// Optional build macro: IRQ_GEN_EXT_SYNC_EN adds a 2-flop synchronizer on
// ext_irq_i; without it ext_irq_i must already be synchronous to clk.
//
// state    | meaning
// S_IDLE   | no interrupt driven; lock highest masked pending source
// S_ASSERT | irq_o holds locked source until ack or withdrawal
// S_GAP    | one quiet cycle after an ack before re-arbitration
module irq_gen
  import irq_gen_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        ext_irq_i,
  input  logic        dbg_req_i,
  input  logic        int_ack_i,
  output logic [3:0]  irq_o
);

  irq_state_e  r_state;
  logic [3:0]  r_irq;
  logic [3:0]  r_locked;
  logic        r_msip;
  logic [3:0]  r_irq_en;
  logic        r_dbg_latch;
  logic        r_dbg_prev;
  logic [31:0] r_rdata;

  logic [2:0]  w_word;
  logic        w_wr;
  logic        w_rd;
  logic        w_ext;
  logic        w_timer_pend;
  logic [3:0]  w_pend;
  logic [3:0]  w_mpend;
  logic        w_dbg_rise;
  logic        w_ack_dbg;
  logic [31:0] w_mtime_lo;
  logic [31:0] w_mtime_hi;
  logic [31:0] w_mtimecmp_lo;
  logic [31:0] w_mtimecmp_hi;
  logic [31:0] w_rdata_nxt;
  logic        w_unused_addr;

  assign w_word        = addr_i[4:2];
  assign w_wr          = sel_i && we_i;
  assign w_rd          = sel_i && !we_i;
  assign w_unused_addr = ^addr_i[1:0];

`ifdef IRQ_GEN_EXT_SYNC_EN
  logic [1:0] r_ext_sync;

  // Two-stage synchronizer for the asynchronous external request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ext_sync <= 2'b00;
    else     r_ext_sync <= {r_ext_sync[0], ext_irq_i};
  end

  assign w_ext = r_ext_sync[1];
`else
  assign w_ext = ext_irq_i;
`endif

  irq_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (w_wr),
    .i_word        (w_word),
    .i_wdata       (wdata_i),
    .o_timer_pend  (w_timer_pend),
    .o_mtime_lo    (w_mtime_lo),
    .o_mtime_hi    (w_mtime_hi),
    .o_mtimecmp_lo (w_mtimecmp_lo),
    .o_mtimecmp_hi (w_mtimecmp_hi)
  );

  assign w_pend     = {r_dbg_latch, w_ext, w_timer_pend, r_msip};
  assign w_mpend    = w_pend & r_irq_en;
  assign w_dbg_rise = dbg_req_i && !r_dbg_prev;
  assign w_ack_dbg  = int_ack_i && (r_state == S_ASSERT) && (r_locked == IRQ_DBG);

  // Software-visible control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msip   <= 1'b0;
      r_irq_en <= 4'b1111;
    end else if (w_wr) begin
      if (w_word == W_MSIP)   r_msip   <= wdata_i[0];
      if (w_word == W_IRQ_EN) r_irq_en <= wdata_i[3:0];
    end
  end

  // Debug request edge latch; a new rising edge beats a same-cycle ack clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dbg_prev  <= 1'b0;
      r_dbg_latch <= 1'b0;
    end else begin
      r_dbg_prev  <= dbg_req_i;
      r_dbg_latch <= w_dbg_rise || (r_dbg_latch && !w_ack_dbg);
    end
  end

  // Arbitration FSM with registered one-hot output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_irq    <= 4'b0000;
      r_locked <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mpend != 4'b0000) begin
            r_locked <= irq_prio_pick(w_mpend);
            r_irq    <= irq_prio_pick(w_mpend);
            r_state  <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (int_ack_i) begin
            r_irq    <= 4'b0000;
            r_locked <= 4'b0000;
            r_state  <= S_GAP;
          end else if ((w_mpend & r_locked) == 4'b0000) begin
            r_irq    <= 4'b0000;
            r_locked <= 4'b0000;
            r_state  <= S_IDLE;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_irq    <= 4'b0000;
          r_locked <= 4'b0000;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Read-back mux; unmapped words read zero
  always_comb begin
    w_rdata_nxt = '0;
    case (w_word)
      W_MSIP:        w_rdata_nxt = {31'b0, r_msip};
      W_MTIMECMP_LO: w_rdata_nxt = w_mtimecmp_lo;
      W_MTIMECMP_HI: w_rdata_nxt = w_mtimecmp_hi;
      W_MTIME_LO:    w_rdata_nxt = w_mtime_lo;
      W_MTIME_HI:    w_rdata_nxt = w_mtime_hi;
      W_IRQ_EN:      w_rdata_nxt = {28'b0, r_irq_en};
      W_STATUS:      w_rdata_nxt = {24'b0, r_locked, w_pend};
      default:       w_rdata_nxt = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata_nxt;
  end

  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_irq_gen.sv
`timescale 1ns/1ps
module tb_irq_gen;
  import irq_gen_pkg::*;

  localparam int unsigned P = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ext_irq_i;
  logic        dbg_req_i;
  logic        int_ack_i;
  logic [3:0]  irq_o;

  always #5 clk = ~clk;

  irq_gen #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_i     (sel_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .ext_irq_i (ext_irq_i),
    .dbg_req_i (dbg_req_i),
    .int_ack_i (int_ack_i),
    .irq_o     (irq_o)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: plain numbers for time, one "currently raised"
  // code (0 = nothing raised) and a quiet-cycle flag after an ack.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_dbg, m_dbg_prev, m_quiet;
  logic [3:0]  m_en, m_irq;
  logic [31:0] m_rdata;
  int unsigned m_cnt;
`ifdef IRQ_GEN_EXT_SYNC_EN
  logic [1:0]  m_sync;
`endif

  function automatic logic [3:0] top_prio(input logic [3:0] p);
    for (int b = 3; b >= 0; b--)
      if (p[b]) return 4'(1 << b);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0; m_cmp = {64{1'b1}}; m_msip = 1'b0; m_en = 4'hF;
    m_dbg = 1'b0; m_dbg_prev = 1'b0; m_irq = 4'b0; m_quiet = 1'b0;
    m_rdata = 32'd0; m_cnt = 0;
`ifdef IRQ_GEN_EXT_SYNC_EN
    m_sync = 2'b00;
`endif
  endtask

  task automatic model_edge(input logic sel, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic ext, input logic dbg,
                            input logic ack);
    logic [3:0]  pend, mpend;
    logic        ext_src, ack_dbg, tick, wr_mt;
    logic [63:0] mt;
`ifdef IRQ_GEN_EXT_SYNC_EN
    ext_src = m_sync[1];
    m_sync  = {m_sync[0], ext};
`else
    ext_src = ext;
`endif
    pend  = {m_dbg, ext_src, (m_mtime >= m_cmp), m_msip};
    mpend = pend & m_en;
    if (sel && !we) begin
      case (int'(a) / 4)
        0: m_rdata = {31'd0, m_msip};
        1: m_rdata = m_cmp[31:0];
        2: m_rdata = m_cmp[63:32];
        3: m_rdata = m_mtime[31:0];
        4: m_rdata = m_mtime[63:32];
        5: m_rdata = {28'd0, m_en};
        6: m_rdata = {24'd0, m_irq, pend};
        default: m_rdata = 32'd0;
      endcase
    end
    ack_dbg = 1'b0;
    if (m_quiet) begin
      m_quiet = 1'b0;
    end else if (m_irq != 4'b0) begin
      if (ack) begin
        ack_dbg = (m_irq == 4'b1000);
        m_irq   = 4'b0;
        m_quiet = 1'b1;
      end else if ((mpend & m_irq) == 4'b0) begin
        m_irq = 4'b0;
      end
    end else if (mpend != 4'b0) begin
      m_irq = top_prio(mpend);
    end
    m_dbg      = (dbg && !m_dbg_prev) || (m_dbg && !ack_dbg);
    m_dbg_prev = dbg;
    mt    = m_mtime;
    wr_mt = 1'b0;
    if (sel && we) begin
      case (int'(a) / 4)
        0: m_msip = d[0];
        1: m_cmp[31:0] = d;
        2: m_cmp[63:32] = d;
        3: begin mt[31:0] = d; wr_mt = 1'b1; end
        4: begin mt[63:32] = d; wr_mt = 1'b1; end
        5: m_en = d[3:0];
        default: ;
      endcase
    end
    tick = (m_cnt == P - 1);
    if (!wr_mt && tick) mt = m_mtime + 64'd1;
    m_mtime = mt;
    m_cnt   = tick ? 0 : m_cnt + 1;
  endtask

  task automatic step(input logic sel, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic ack);
    sel_i = sel; we_i = we; addr_i = a; wdata_i = d; int_ack_i = ack;
    @(posedge clk);
    model_edge(sel, we, a, d, ext_irq_i, dbg_req_i, ack);
    #1;
    check("irq_o", 64'(irq_o), 64'(m_irq));
    check("rdata_o", 64'(rdata_o), 64'(m_rdata));
    sel_i = 1'b0; we_i = 1'b0; int_ack_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1'b1, 1'b1, a, d, 1'b0); endtask
  task automatic rd(input logic [4:0] a); step(1'b1, 1'b0, a, 32'd0, 1'b0); endtask
  task automatic idle(); step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0); endtask
  task automatic ack(); step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1); endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; sel_i = 1'b0; we_i = 1'b0; addr_i = 5'd0; wdata_i = 32'd0;
    ext_irq_i = 1'b0; dbg_req_i = 1'b0; int_ack_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_irq", 64'(irq_o), 64'(0));
    check("rst_rdata", 64'(rdata_o), 64'(0));
    rd(IRQ_GEN_MTIMECMP_LO);
    check("rst_cmp_lo", 64'(rdata_o), 64'(32'hFFFF_FFFF));
    rd(IRQ_GEN_IRQ_EN);
    check("rst_irq_en", 64'(rdata_o), 64'(4'hF));

    // software interrupt, ack gap, re-assertion
    wr(IRQ_GEN_MSIP, 32'd1);
    check("soft_early", 64'(irq_o), 64'(0));
    idle();
    check("soft_assert", 64'(irq_o), 64'(IRQ_SOFT));
    ack();
    check("soft_gap0", 64'(irq_o), 64'(0));
    idle();
    check("soft_gap1", 64'(irq_o), 64'(0));
    idle();
    check("soft_reassert", 64'(irq_o), 64'(IRQ_SOFT));
    wr(IRQ_GEN_MSIP, 32'd0);
    idle();
    check("soft_withdraw", 64'(irq_o), 64'(0));

    // timer fires when mtime reaches 0x10, withdrawn by moving mtimecmp
    wr(IRQ_GEN_MTIME_LO, 32'd0);
    wr(IRQ_GEN_MTIME_HI, 32'd0);
    wr(IRQ_GEN_MTIMECMP_LO, 32'h10);
    wr(IRQ_GEN_MTIMECMP_HI, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (m_mtime == 64'h10) begin
        check("timer_before", 64'(irq_o), 64'(0));
        idle();
        check("timer_assert", 64'(irq_o), 64'(IRQ_TIMER));
        seen = 1'b1;
        break;
      end
    end
    check("timer_reached", 64'(seen), 64'(1));
    wr(IRQ_GEN_MTIMECMP_HI, 32'hFFFF_FFFF);
    idle();
    check("timer_withdraw", 64'(irq_o), 64'(0));

    // debug beats simultaneous software; ack clears debug latch
    dbg_req_i = 1'b1;
    wr(IRQ_GEN_MSIP, 32'd1);
    idle();
    check("dbg_first", 64'(irq_o), 64'(IRQ_DBG));
    rd(IRQ_GEN_STATUS);
    check("status_dbg", 64'(rdata_o), 64'(32'h89));
    ack();
    idle();
    idle();
    check("soft_after_dbg", 64'(irq_o), 64'(IRQ_SOFT));
    rd(IRQ_GEN_STATUS);
    check("status_soft", 64'(rdata_o), 64'(32'h11));
    dbg_req_i = 1'b0;

    // external arrival does not preempt a locked software interrupt
    ext_irq_i = 1'b1;
    repeat (3) idle();
    check("ext_no_preempt", 64'(irq_o), 64'(IRQ_SOFT));
    ack();
    idle();
    idle();
    check("ext_after_ack", 64'(irq_o), 64'(IRQ_EXT));
    ext_irq_i = 1'b0;
    wr(IRQ_GEN_MSIP, 32'd0);
    repeat (4) idle();

    // 64-bit wrap and write-over-increment priority
    wr(IRQ_GEN_MTIME_HI, 32'hFFFF_FFFF);
    wr(IRQ_GEN_MTIME_LO, 32'hFFFF_FFFF);
    rd(IRQ_GEN_MTIME_LO);
    check("pre_wrap_lo", 64'(rdata_o), 64'(32'hFFFF_FFFF));
    rd(IRQ_GEN_MTIME_LO);
    check("wrap_lo", 64'(rdata_o), 64'(0));
    rd(IRQ_GEN_MTIME_HI);
    check("wrap_hi", 64'(rdata_o), 64'(0));
    wr(IRQ_GEN_MTIME_LO, 32'h0000_1234);
    rd(IRQ_GEN_MTIME_LO);
    check("wr_beats_inc", 64'(rdata_o), 64'(32'h0000_1234));
    repeat (3) idle();

    // asynchronous reset while asserting
    wr(IRQ_GEN_MSIP, 32'd1);
    idle();
    rd(IRQ_GEN_MTIMECMP_LO);
    check("pre_rst_irq", 64'(irq_o), 64'(IRQ_SOFT));
    #2 rst = 1'b1;
    #1;
    check("rst_async_irq", 64'(irq_o), 64'(0));
    check("rst_async_rdata", 64'(rdata_o), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd(IRQ_GEN_MSIP);
    check("rst_msip", 64'(rdata_o), 64'(0));
    rd(IRQ_GEN_MTIMECMP_LO);
    check("rst_cmp_lo2", 64'(rdata_o), 64'(32'hFFFF_FFFF));
    rd(IRQ_GEN_MTIMECMP_HI);
    check("rst_cmp_hi2", 64'(rdata_o), 64'(32'hFFFF_FFFF));

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [4:0]  a;
      logic [31:0] d;
      r = $urandom_range(0, 15);
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ext_irq_i = ~ext_irq_i;
      if ($urandom_range(0, 9) == 0) dbg_req_i = ~dbg_req_i;
      case (int'(a) / 4)
        0: d = 32'($urandom_range(0, 1));
        1: d = m_mtime[31:0] + 32'($urandom_range(0, 24)) - 32'd4;
        2: d = m_mtime[63:32] + 32'($urandom_range(0, 1));
        3: d = m_mtime[31:0] - 32'($urandom_range(0, 16));
        4: d = m_mtime[63:32] + 32'($urandom_range(0, 1));
        default: d = $urandom;
      endcase
      if (r < 5)       wr(a, d);
      else if (r < 9)  rd(a);
      else if (r < 12) ack();
      else             idle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
